adder_result_fifo: RTL and testbench

Result collection stage downstream of the BF16/INT8 single-cycle adder/subtractor. It re-aligns the adder's combinational overflow flag and the issue-cycle INT8 mode bit with the registered sum, which arrives one cycle later. It buffers the tagged results in a FIFO with a valid/ready output and keeps sticky status and a drop counter. The adder has no back-pressure, so this block also raises an almost-full flag that the issuing logic uses to throttle `i_vld`.

---
 rtl/adder_result_fifo_if.sv | 32 +++
 rtl/adder_result_fifo.sv | 124 ++++++++++++
 tb/tb_adder_result_fifo.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_result_fifo_if.sv
// Handshake bundle between the adder result path, the result FIFO and its consumer.
// The FIFO takes the slave view; whatever drives the adder side and consumes results takes the master view.
interface adder_result_fifo_if #(
    parameter int CNT_W = 4
);
    logic              i_iss_vld;
    logic              i_iss_int8;
    logic              i_iss_ovf;
    logic [15:0]       i_res;
    logic              i_res_vld;
    logic              i_clr_sticky;
    logic              i_rdy;
    logic              o_vld;
    logic [15:0]       o_res;
    logic              o_ovf;
    logic              o_int8;
    logic              o_afull;
    logic [CNT_W-1:0]  o_count;
    logic              o_sticky_ovf;
    logic              o_sticky_inf;
    logic [15:0]       o_drop_cnt;

    modport master (
        output i_iss_vld, i_iss_int8, i_iss_ovf, i_res, i_res_vld, i_clr_sticky, i_rdy,
        input  o_vld, o_res, o_ovf, o_int8, o_afull, o_count, o_sticky_ovf, o_sticky_inf, o_drop_cnt
    );

    modport slave (
        input  i_iss_vld, i_iss_int8, i_iss_ovf, i_res, i_res_vld, i_clr_sticky, i_rdy,
        output o_vld, o_res, o_ovf, o_int8, o_afull, o_count, o_sticky_ovf, o_sticky_inf, o_drop_cnt
    );
endinterface

// File: rtl/adder_result_fifo.sv
// Result collection stage for the BF16/INT8 adder: aligns issue-cycle tags with the
// registered sum, buffers tagged results, and tracks sticky status and dropped results.
module adder_result_fifo #(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    adder_result_fifo_if.slave bus
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);

    // Tags sampled in the issue cycle so they line up with the sum one cycle later.
    logic             ovf_tag_reg;
    logic             int8_tag_reg;

    logic [17:0]      mem [DEPTH];
    logic [17:0]      head_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             afull_reg;
    logic             sticky_ovf_reg;
    logic             sticky_inf_reg;
    logic [15:0]      drop_cnt_reg;

    logic             vld;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic             inf_hit;
    logic [17:0]      wr_data;

    always_comb begin
        vld         = (count_reg != '0);
        full        = (count_reg == DEPTH_C);
        pop         = vld & bus.i_rdy;
        // A full FIFO can still accept when the head leaves in the same cycle.
        push        = bus.i_res_vld & (~full | pop);
        drop        = bus.i_res_vld & full & ~pop;
        wr_data     = {ovf_tag_reg, int8_tag_reg, bus.i_res};
        inf_hit     = ~int8_tag_reg & (bus.i_res[14:7] == 8'hFF);
        wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
        count_next  = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage array: write port plus registered read of the next head address.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // The RAM read returns the old word on a same-address write, so an entry that
    // becomes the head at this edge is taken straight from the write data instead.
    always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= wr_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_tag_reg    <= 1'b0;
            int8_tag_reg   <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            afull_reg      <= 1'b0;
            sticky_ovf_reg <= 1'b0;
            sticky_inf_reg <= 1'b0;
            drop_cnt_reg   <= '0;
        end else begin
            ovf_tag_reg  <= bus.i_iss_ovf  & bus.i_iss_vld;
            int8_tag_reg <= bus.i_iss_int8 & bus.i_iss_vld;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            afull_reg    <= (count_next >= AFULL_C);

            // A set on an accepted write takes priority over a same-cycle clear.
            if (push && ovf_tag_reg) begin
                sticky_ovf_reg <= 1'b1;
            end else if (bus.i_clr_sticky) begin
                sticky_ovf_reg <= 1'b0;
            end

            if (push && inf_hit) begin
                sticky_inf_reg <= 1'b1;
            end else if (bus.i_clr_sticky) begin
                sticky_inf_reg <= 1'b0;
            end

            if (drop && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign bus.o_vld        = vld;
    assign bus.o_res        = head_reg[15:0];
    assign bus.o_int8       = head_reg[16];
    assign bus.o_ovf        = head_reg[17];
    assign bus.o_afull      = afull_reg;
    assign bus.o_count      = count_reg;
    assign bus.o_sticky_ovf = sticky_ovf_reg;
    assign bus.o_sticky_inf = sticky_inf_reg;
    assign bus.o_drop_cnt   = drop_cnt_reg;
endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed bench for adder_result_fifo: table-driven result streams plus hand-written
// sequences for reset, full push/pop, sticky set/clear priority and mid-run reset.
module tb_adder_result_fifo;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_result_fifo_if #(.CNT_W(4)) bus();

    adder_result_fifo #(
        .DEPTH(8),
        .AFULL_LVL(6),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic        iss_ovf;
        logic        iss_int8;
        logic [15:0] res;
        logic [15:0] exp_res;
        logic        exp_ovf;
        logic        exp_int8;
    } vec_t;

    vec_t vecs[32];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Non-issue cycles carry ones on the tag inputs so the valid masking is exercised.
    task automatic idle_issue();
        bus.i_iss_vld  = 1'b0;
        bus.i_iss_ovf  = 1'b1;
        bus.i_iss_int8 = 1'b1;
    endtask

    task automatic chk_head(input string name, input int idx);
        chk({name, ".vld"},  32'(bus.o_vld), 32'd1);
        chk({name, ".res"},  32'(bus.o_res), 32'(vecs[idx].exp_res));
        chk({name, ".ovf"},  32'(bus.o_ovf), 32'(vecs[idx].exp_ovf));
        chk({name, ".int8"}, 32'(bus.o_int8), 32'(vecs[idx].exp_int8));
        $display("head vec %0d: res=0x%04h ovf=%0b int8=%0b", idx, bus.o_res, bus.o_ovf, bus.o_int8);
    endtask

    // Pipelined issue/result stream of n table entries.  stream=1: consumer always
    // ready, each result must be the head for exactly one cycle.  stream=0: consumer
    // stalled, occupancy/afull/drop are tracked from count_base and drop_base.
    task automatic send(input int start, input int n, input bit stream,
                        input int count_base, input int drop_base);
        int exp_cnt;
        int exp_drop;
        for (int c = 0; c <= n; c++) begin
            if (c < n) begin
                bus.i_iss_vld  = 1'b1;
                bus.i_iss_ovf  = vecs[start + c].iss_ovf;
                bus.i_iss_int8 = vecs[start + c].iss_int8;
            end else begin
                idle_issue();
            end
            bus.i_res_vld = (c > 0);
            bus.i_res     = (c > 0) ? vecs[start + c - 1].res : 16'h0000;
            bus.i_rdy     = stream;
            tick();
            if (c > 0) begin
                if (stream) begin
                    chk_head("stream", start + c - 1);
                    chk("stream.count", 32'(bus.o_count), 32'd1);
                end else begin
                    exp_cnt  = (count_base + c > 8) ? 8 : count_base + c;
                    exp_drop = drop_base + ((count_base + c > 8) ? count_base + c - 8 : 0);
                    chk("fill.count", 32'(bus.o_count), 32'(exp_cnt));
                    chk("fill.afull", 32'(bus.o_afull), (exp_cnt >= 6) ? 32'd1 : 32'd0);
                    chk("fill.drop",  32'(bus.o_drop_cnt), 32'(exp_drop));
                    $display("fill step %0d: count=%0d afull=%0b drop=%0d",
                             c, bus.o_count, bus.o_afull, bus.o_drop_cnt);
                end
            end
        end
        idle_issue();
        bus.i_res_vld = 1'b0;
    endtask

    task automatic drain(input int start, input int n);
        bus.i_rdy = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk_head("drain", start + k);
            tick();
        end
        chk("drain.empty_vld", 32'(bus.o_vld), 32'd0);
        chk("drain.empty_count", 32'(bus.o_count), 32'd0);
    endtask

    task automatic one_result(input logic [15:0] res, input logic ovf, input logic int8,
                              input logic clr);
        bus.i_iss_vld  = 1'b1;
        bus.i_iss_ovf  = ovf;
        bus.i_iss_int8 = int8;
        tick();
        idle_issue();
        bus.i_res_vld    = 1'b1;
        bus.i_res        = res;
        bus.i_clr_sticky = clr;
        tick();
        bus.i_res_vld    = 1'b0;
        bus.i_clr_sticky = 1'b0;
    endtask

    initial begin
        // Tag alignment entries
        vecs[0] = '{1'b1, 1'b0, 16'h1111, 16'h1111, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h2222, 16'h2222, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 16'h3333, 16'h3333, 1'b1, 1'b1};
        // Fill-and-drop run: A000..A009, INT8 mode, no overflow
        for (int k = 0; k < 10; k++)
            vecs[3 + k] = '{1'b0, 1'b1, 16'hA000 + 16'(k), 16'hA000 + 16'(k), 1'b0, 1'b1};
        // Full push/pop run: B000..B007 fill, B008 pushed while popping
        for (int k = 0; k < 9; k++)
            vecs[13 + k] = '{1'b0, 1'b1, 16'hB000 + 16'(k), 16'hB000 + 16'(k), 1'b0, 1'b1};
        // Pre-reset content, sets both sticky flags
        vecs[22] = '{1'b0, 1'b1, 16'hC000, 16'hC000, 1'b0, 1'b1};
        vecs[23] = '{1'b1, 1'b1, 16'hC001, 16'hC001, 1'b1, 1'b1};
        vecs[24] = '{1'b0, 1'b0, 16'h7F80, 16'h7F80, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 1'b1, 16'hC003, 16'hC003, 1'b0, 1'b1};
        vecs[26] = '{1'b0, 1'b1, 16'hC004, 16'hC004, 1'b0, 1'b1};

        rst              = 1'b1;
        bus.i_res        = 16'h0000;
        bus.i_res_vld    = 1'b0;
        bus.i_clr_sticky = 1'b0;
        bus.i_rdy        = 1'b1;
        idle_issue();

        // Reset held two cycles, checked while still asserted
        tick();
        tick();
        chk("rst.vld",        32'(bus.o_vld), 32'd0);
        chk("rst.count",      32'(bus.o_count), 32'd0);
        chk("rst.afull",      32'(bus.o_afull), 32'd0);
        chk("rst.sticky_ovf", 32'(bus.o_sticky_ovf), 32'd0);
        chk("rst.sticky_inf", 32'(bus.o_sticky_inf), 32'd0);
        chk("rst.drop",       32'(bus.o_drop_cnt), 32'd0);
        rst = 1'b0;

        // Single issue: visible two cycles after issue, no bypass
        bus.i_iss_vld  = 1'b1;
        bus.i_iss_ovf  = 1'b0;
        bus.i_iss_int8 = 1'b0;
        chk("single.vld_T", 32'(bus.o_vld), 32'd0);
        tick();
        idle_issue();
        bus.i_res_vld = 1'b1;
        bus.i_res     = 16'h3F80;
        chk("single.vld_T1", 32'(bus.o_vld), 32'd0);
        tick();
        bus.i_res_vld = 1'b0;
        chk("single.vld_T2", 32'(bus.o_vld), 32'd1);
        chk("single.res",    32'(bus.o_res), 32'h3F80);
        chk("single.int8",   32'(bus.o_int8), 32'd0);
        chk("single.ovf",    32'(bus.o_ovf), 32'd0);
        chk("single.count",  32'(bus.o_count), 32'd1);
        $display("single: res=0x%04h", bus.o_res);
        tick();
        chk("single.vld_T3",   32'(bus.o_vld), 32'd0);
        chk("single.count_T3", 32'(bus.o_count), 32'd0);
        chk("single.sticky_inf", 32'(bus.o_sticky_inf), 32'd0);

        // Tag alignment with back-to-back issues and a ready consumer
        send(0, 3, 1'b1, 0, 0);
        chk("tags.sticky_ovf", 32'(bus.o_sticky_ovf), 32'd1);
        // Result without a preceding issue must carry zero tags
        bus.i_res_vld = 1'b1;
        bus.i_res     = 16'h5555;
        tick();
        bus.i_res_vld = 1'b0;
        chk("orphan.res",  32'(bus.o_res), 32'h5555);
        chk("orphan.ovf",  32'(bus.o_ovf), 32'd0);
        chk("orphan.int8", 32'(bus.o_int8), 32'd0);
        tick();
        chk("orphan.empty", 32'(bus.o_vld), 32'd0);

        // Fill and drop: ten results into eight entries with the consumer stalled
        send(3, 10, 1'b0, 0, 0);
        drain(3, 8);
        chk("fill.drop_after_drain", 32'(bus.o_drop_cnt), 32'd2);

        // Full FIFO with simultaneous push and pop
        send(13, 8, 1'b0, 0, 2);
        bus.i_iss_vld  = 1'b1;
        bus.i_iss_ovf  = vecs[21].iss_ovf;
        bus.i_iss_int8 = vecs[21].iss_int8;
        bus.i_rdy      = 1'b0;
        tick();
        idle_issue();
        bus.i_res_vld = 1'b1;
        bus.i_res     = vecs[21].res;
        bus.i_rdy     = 1'b1;
        chk("fullpp.head_before", 32'(bus.o_res), 32'hB000);
        tick();
        bus.i_res_vld = 1'b0;
        bus.i_rdy     = 1'b0;
        chk("fullpp.count", 32'(bus.o_count), 32'd8);
        chk("fullpp.drop",  32'(bus.o_drop_cnt), 32'd2);
        chk("fullpp.afull", 32'(bus.o_afull), 32'd1);
        drain(14, 8);

        // Sticky inf: clear alone, INT8 mode blocks, set, set-wins-over-clear, clear
        bus.i_clr_sticky = 1'b1;
        tick();
        bus.i_clr_sticky = 1'b0;
        chk("clr.sticky_ovf", 32'(bus.o_sticky_ovf), 32'd0);
        chk("clr.sticky_inf", 32'(bus.o_sticky_inf), 32'd0);
        one_result(16'h7F80, 1'b0, 1'b1, 1'b0);
        chk("inf.int8_mode", 32'(bus.o_sticky_inf), 32'd0);
        chk("inf.int8_head", 32'(bus.o_int8), 32'd1);
        one_result(16'h7F80, 1'b0, 1'b0, 1'b0);
        chk("inf.set", 32'(bus.o_sticky_inf), 32'd1);
        one_result(16'hFF80, 1'b0, 1'b0, 1'b1);
        chk("inf.set_wins", 32'(bus.o_sticky_inf), 32'd1);
        chk("inf.ovf_clear", 32'(bus.o_sticky_ovf), 32'd0);
        bus.i_clr_sticky = 1'b1;
        tick();
        bus.i_clr_sticky = 1'b0;
        chk("inf.cleared", 32'(bus.o_sticky_inf), 32'd0);
        chk("inf.drained", 32'(bus.o_vld), 32'd0);

        // Reset mid-operation with a result arriving and tags pending
        send(22, 5, 1'b0, 0, 2);
        chk("pre_rst.sticky_ovf", 32'(bus.o_sticky_ovf), 32'd1);
        chk("pre_rst.sticky_inf", 32'(bus.o_sticky_inf), 32'd1);
        bus.i_iss_vld  = 1'b1;
        bus.i_iss_ovf  = 1'b1;
        bus.i_iss_int8 = 1'b1;
        tick();
        bus.i_res_vld = 1'b1;
        bus.i_res     = 16'hDDDD;
        rst           = 1'b1;
        tick();
        rst = 1'b0;
        idle_issue();
        bus.i_res     = 16'h4444;
        chk("midrst.vld",        32'(bus.o_vld), 32'd0);
        chk("midrst.count",      32'(bus.o_count), 32'd0);
        chk("midrst.afull",      32'(bus.o_afull), 32'd0);
        chk("midrst.drop",       32'(bus.o_drop_cnt), 32'd0);
        chk("midrst.sticky_ovf", 32'(bus.o_sticky_ovf), 32'd0);
        chk("midrst.sticky_inf", 32'(bus.o_sticky_inf), 32'd0);
        tick();
        bus.i_res_vld = 1'b0;
        chk("postrst.vld",   32'(bus.o_vld), 32'd1);
        chk("postrst.res",   32'(bus.o_res), 32'h4444);
        chk("postrst.ovf",   32'(bus.o_ovf), 32'd0);
        chk("postrst.int8",  32'(bus.o_int8), 32'd0);
        chk("postrst.count", 32'(bus.o_count), 32'd1);
        chk("postrst.sticky_ovf", 32'(bus.o_sticky_ovf), 32'd0);
        bus.i_rdy = 1'b1;
        tick();
        chk("postrst.empty", 32'(bus.o_vld), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
